// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core constants and the fetch-responder state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  // Canonical RV32 NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_mem_responder.sv
// ============================================================================
// Module      : instr_mem_responder
// Description : Assembles 32-bit instructions from two 16-bit memory beats
//               and presents them to the decode register with stall/flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_responder
  import core_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_pc,
  input  logic              de_stall,
  input  logic              de_flush,
  output logic [31:0]       de_instr,
  output logic              fetch_busy,
  output logic              misalign_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       lo_q, lo_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       instr_d;
  logic              err_d;
  logic              fetch_done;
  logic [31:0]       fetch_word;

  // Only the low ADDR_W bits of the fetch address reach the memory.
  generate
    if (ADDR_W < 32) begin : g_pc_trunc
      logic unused_pc_hi;
      assign unused_pc_hi = ^if_pc[31:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      lo_q         <= '0;
      buf_q        <= '0;
      de_instr     <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      lo_q         <= lo_d;
      buf_q        <= buf_d;
      de_instr     <= instr_d;
      misalign_err <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lo_d       = lo_q;
    buf_d      = buf_q;
    instr_d    = de_instr;
    err_d      = misalign_err;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fetch_busy = 1'b1;
    fetch_done = 1'b0;
    fetch_word = NOP_INSTR;

    case (state_q)
      IDLE: begin
        pc_d    = if_pc[ADDR_W-1:0];
        state_d = LO;
      end
      LO: begin
        if (pc_q[1:0] == 2'b00) begin
          mem_req  = 1'b1;
          mem_addr = pc_q;
          if (mem_rvalid) begin
            lo_d    = mem_rdata;
            state_d = HI;
          end
        end else begin
          // A misaligned fetch completes at once with a NOP.
          err_d      = 1'b1;
          fetch_done = 1'b1;
        end
      end
      HI: begin
        mem_req    = 1'b1;
        mem_addr   = pc_q + ADDR_W'(2);
        fetch_busy = !mem_rvalid;
        if (mem_rvalid) begin
          fetch_done = 1'b1;
          fetch_word = {mem_rdata, lo_q};
        end
      end
      HOLD: begin
        fetch_busy = 1'b0;
        if (!de_stall) begin
          instr_d = buf_q;
          pc_d    = if_pc[ADDR_W-1:0];
          state_d = LO;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch_done) begin
      if (de_stall) begin
        buf_d   = fetch_word;
        state_d = HOLD;
      end else begin
        instr_d = fetch_word;
        pc_d    = if_pc[ADDR_W-1:0];
        state_d = LO;
      end
    end

    if (de_flush) begin
      instr_d = NOP_INSTR;
      lo_d    = '0;
      buf_d   = '0;
      state_d = IDLE;
    end
  end

endmodule

`default_nettype wire
